// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative SubBytes stage.
//   AES_STATE_W / AES_NUM_BYTES : state geometry
//   sb_state_e                  : SubBytes controller states
//   sbox_fwd / sbox_inv         : forward and inverse S-box lookup tables
package aes_pkg;

  localparam int unsigned AES_STATE_W   = 128;
  localparam int unsigned AES_NUM_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sb_state_e;

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    case (b)
      8'h00: r = 8'h63; 8'h01: r = 8'h7c; 8'h02: r = 8'h77; 8'h03: r = 8'h7b; 8'h04: r = 8'hf2; 8'h05: r = 8'h6b; 8'h06: r = 8'h6f; 8'h07: r = 8'hc5;
      8'h08: r = 8'h30; 8'h09: r = 8'h01; 8'h0a: r = 8'h67; 8'h0b: r = 8'h2b; 8'h0c: r = 8'hfe; 8'h0d: r = 8'hd7; 8'h0e: r = 8'hab; 8'h0f: r = 8'h76;
      8'h10: r = 8'hca; 8'h11: r = 8'h82; 8'h12: r = 8'hc9; 8'h13: r = 8'h7d; 8'h14: r = 8'hfa; 8'h15: r = 8'h59; 8'h16: r = 8'h47; 8'h17: r = 8'hf0;
      8'h18: r = 8'had; 8'h19: r = 8'hd4; 8'h1a: r = 8'ha2; 8'h1b: r = 8'haf; 8'h1c: r = 8'h9c; 8'h1d: r = 8'ha4; 8'h1e: r = 8'h72; 8'h1f: r = 8'hc0;
      8'h20: r = 8'hb7; 8'h21: r = 8'hfd; 8'h22: r = 8'h93; 8'h23: r = 8'h26; 8'h24: r = 8'h36; 8'h25: r = 8'h3f; 8'h26: r = 8'hf7; 8'h27: r = 8'hcc;
      8'h28: r = 8'h34; 8'h29: r = 8'ha5; 8'h2a: r = 8'he5; 8'h2b: r = 8'hf1; 8'h2c: r = 8'h71; 8'h2d: r = 8'hd8; 8'h2e: r = 8'h31; 8'h2f: r = 8'h15;
      8'h30: r = 8'h04; 8'h31: r = 8'hc7; 8'h32: r = 8'h23; 8'h33: r = 8'hc3; 8'h34: r = 8'h18; 8'h35: r = 8'h96; 8'h36: r = 8'h05; 8'h37: r = 8'h9a;
      8'h38: r = 8'h07; 8'h39: r = 8'h12; 8'h3a: r = 8'h80; 8'h3b: r = 8'he2; 8'h3c: r = 8'heb; 8'h3d: r = 8'h27; 8'h3e: r = 8'hb2; 8'h3f: r = 8'h75;
      8'h40: r = 8'h09; 8'h41: r = 8'h83; 8'h42: r = 8'h2c; 8'h43: r = 8'h1a; 8'h44: r = 8'h1b; 8'h45: r = 8'h6e; 8'h46: r = 8'h5a; 8'h47: r = 8'ha0;
      8'h48: r = 8'h52; 8'h49: r = 8'h3b; 8'h4a: r = 8'hd6; 8'h4b: r = 8'hb3; 8'h4c: r = 8'h29; 8'h4d: r = 8'he3; 8'h4e: r = 8'h2f; 8'h4f: r = 8'h84;
      8'h50: r = 8'h53; 8'h51: r = 8'hd1; 8'h52: r = 8'h00; 8'h53: r = 8'hed; 8'h54: r = 8'h20; 8'h55: r = 8'hfc; 8'h56: r = 8'hb1; 8'h57: r = 8'h5b;
      8'h58: r = 8'h6a; 8'h59: r = 8'hcb; 8'h5a: r = 8'hbe; 8'h5b: r = 8'h39; 8'h5c: r = 8'h4a; 8'h5d: r = 8'h4c; 8'h5e: r = 8'h58; 8'h5f: r = 8'hcf;
      8'h60: r = 8'hd0; 8'h61: r = 8'hef; 8'h62: r = 8'haa; 8'h63: r = 8'hfb; 8'h64: r = 8'h43; 8'h65: r = 8'h4d; 8'h66: r = 8'h33; 8'h67: r = 8'h85;
      8'h68: r = 8'h45; 8'h69: r = 8'hf9; 8'h6a: r = 8'h02; 8'h6b: r = 8'h7f; 8'h6c: r = 8'h50; 8'h6d: r = 8'h3c; 8'h6e: r = 8'h9f; 8'h6f: r = 8'ha8;
      8'h70: r = 8'h51; 8'h71: r = 8'ha3; 8'h72: r = 8'h40; 8'h73: r = 8'h8f; 8'h74: r = 8'h92; 8'h75: r = 8'h9d; 8'h76: r = 8'h38; 8'h77: r = 8'hf5;
      8'h78: r = 8'hbc; 8'h79: r = 8'hb6; 8'h7a: r = 8'hda; 8'h7b: r = 8'h21; 8'h7c: r = 8'h10; 8'h7d: r = 8'hff; 8'h7e: r = 8'hf3; 8'h7f: r = 8'hd2;
      8'h80: r = 8'hcd; 8'h81: r = 8'h0c; 8'h82: r = 8'h13; 8'h83: r = 8'hec; 8'h84: r = 8'h5f; 8'h85: r = 8'h97; 8'h86: r = 8'h44; 8'h87: r = 8'h17;
      8'h88: r = 8'hc4; 8'h89: r = 8'ha7; 8'h8a: r = 8'h7e; 8'h8b: r = 8'h3d; 8'h8c: r = 8'h64; 8'h8d: r = 8'h5d; 8'h8e: r = 8'h19; 8'h8f: r = 8'h73;
      8'h90: r = 8'h60; 8'h91: r = 8'h81; 8'h92: r = 8'h4f; 8'h93: r = 8'hdc; 8'h94: r = 8'h22; 8'h95: r = 8'h2a; 8'h96: r = 8'h90; 8'h97: r = 8'h88;
      8'h98: r = 8'h46; 8'h99: r = 8'hee; 8'h9a: r = 8'hb8; 8'h9b: r = 8'h14; 8'h9c: r = 8'hde; 8'h9d: r = 8'h5e; 8'h9e: r = 8'h0b; 8'h9f: r = 8'hdb;
      8'ha0: r = 8'he0; 8'ha1: r = 8'h32; 8'ha2: r = 8'h3a; 8'ha3: r = 8'h0a; 8'ha4: r = 8'h49; 8'ha5: r = 8'h06; 8'ha6: r = 8'h24; 8'ha7: r = 8'h5c;
      8'ha8: r = 8'hc2; 8'ha9: r = 8'hd3; 8'haa: r = 8'hac; 8'hab: r = 8'h62; 8'hac: r = 8'h91; 8'had: r = 8'h95; 8'hae: r = 8'he4; 8'haf: r = 8'h79;
      8'hb0: r = 8'he7; 8'hb1: r = 8'hc8; 8'hb2: r = 8'h37; 8'hb3: r = 8'h6d; 8'hb4: r = 8'h8d; 8'hb5: r = 8'hd5; 8'hb6: r = 8'h4e; 8'hb7: r = 8'ha9;
      8'hb8: r = 8'h6c; 8'hb9: r = 8'h56; 8'hba: r = 8'hf4; 8'hbb: r = 8'hea; 8'hbc: r = 8'h65; 8'hbd: r = 8'h7a; 8'hbe: r = 8'hae; 8'hbf: r = 8'h08;
      8'hc0: r = 8'hba; 8'hc1: r = 8'h78; 8'hc2: r = 8'h25; 8'hc3: r = 8'h2e; 8'hc4: r = 8'h1c; 8'hc5: r = 8'ha6; 8'hc6: r = 8'hb4; 8'hc7: r = 8'hc6;
      8'hc8: r = 8'he8; 8'hc9: r = 8'hdd; 8'hca: r = 8'h74; 8'hcb: r = 8'h1f; 8'hcc: r = 8'h4b; 8'hcd: r = 8'hbd; 8'hce: r = 8'h8b; 8'hcf: r = 8'h8a;
      8'hd0: r = 8'h70; 8'hd1: r = 8'h3e; 8'hd2: r = 8'hb5; 8'hd3: r = 8'h66; 8'hd4: r = 8'h48; 8'hd5: r = 8'h03; 8'hd6: r = 8'hf6; 8'hd7: r = 8'h0e;
      8'hd8: r = 8'h61; 8'hd9: r = 8'h35; 8'hda: r = 8'h57; 8'hdb: r = 8'hb9; 8'hdc: r = 8'h86; 8'hdd: r = 8'hc1; 8'hde: r = 8'h1d; 8'hdf: r = 8'h9e;
      8'he0: r = 8'he1; 8'he1: r = 8'hf8; 8'he2: r = 8'h98; 8'he3: r = 8'h11; 8'he4: r = 8'h69; 8'he5: r = 8'hd9; 8'he6: r = 8'h8e; 8'he7: r = 8'h94;
      8'he8: r = 8'h9b; 8'he9: r = 8'h1e; 8'hea: r = 8'h87; 8'heb: r = 8'he9; 8'hec: r = 8'hce; 8'hed: r = 8'h55; 8'hee: r = 8'h28; 8'hef: r = 8'hdf;
      8'hf0: r = 8'h8c; 8'hf1: r = 8'ha1; 8'hf2: r = 8'h89; 8'hf3: r = 8'h0d; 8'hf4: r = 8'hbf; 8'hf5: r = 8'he6; 8'hf6: r = 8'h42; 8'hf7: r = 8'h68;
      8'hf8: r = 8'h41; 8'hf9: r = 8'h99; 8'hfa: r = 8'h2d; 8'hfb: r = 8'h0f; 8'hfc: r = 8'hb0; 8'hfd: r = 8'h54; 8'hfe: r = 8'hbb; 8'hff: r = 8'h16;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    case (b)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single combinational AES S-box lane.
//   in_byte  : byte to substitute
//   inv      : 0 = forward S-box, 1 = inverse S-box
//   out_byte : substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic       inv,
  output logic [7:0] out_byte
);

  always_comb begin
    out_byte = sbox_fwd(in_byte);
    if (inv) out_byte = sbox_inv(in_byte);
  end

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes the 16 state bytes BYTES_PER_CYCLE at a
// time, MSB byte first, through forward or inverse S-box lanes.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake (in_state, in_inv sampled on accept)
//   in_state             : 128-bit state, byte 0 = [127:120]
//   in_inv               : 0 = forward (encrypt), 1 = inverse (decrypt)
//   out_valid / out_ready: output handshake
//   out_state            : substituted state (the working register)
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 4
)
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state
);

  localparam int unsigned NUM_STEPS = AES_NUM_BYTES / BYTES_PER_CYCLE;
  localparam int unsigned CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int unsigned CHUNK_W   = 8 * BYTES_PER_CYCLE;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STEPS - 1);

  sb_state_e              state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic                   inv_q;
  logic [AES_STATE_W-1:0] work, work_nxt;
  logic [6:0]             chunk_hi;
  logic [CHUNK_W-1:0]     chunk_in, chunk_out;

  // Top bit of the chunk addressed by cnt; chunk 0 holds the MSB bytes.
  always_comb chunk_hi = 7'(AES_STATE_W - 1 - 32'(cnt) * CHUNK_W);

  assign chunk_in = work[chunk_hi -: CHUNK_W];

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    aes_sbox u_sbox (
      .in_byte  (chunk_in[CHUNK_W-1-8*g -: 8]),
      .inv      (inv_q),
      .out_byte (chunk_out[CHUNK_W-1-8*g -: 8])
    );
  end

  always_comb begin
    work_nxt = work;
    work_nxt[chunk_hi -: CHUNK_W] = chunk_out;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == LAST_CNT) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      inv_q <= 1'b0;
      work  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_state;
            inv_q <= in_inv;
            cnt   <= '0;
          end
        end
        BUSY: begin
          work <= work_nxt;
          cnt  <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_state = work;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter: directed vectors, handshake corner
// cases, randomized blocks against a GF(2^8) reference, and a BPC sweep.
module tb_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_inv;
  logic         out_ready;
  logic [127:0] in_state;

  logic [4:0]   in_ready_v;
  logic [4:0]   out_valid_v;
  logic [127:0] out_state_v [5];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 5; k++) begin : g_dut
    sub_bytes_iter #(.BYTES_PER_CYCLE(1 << k)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[k]),
      .in_state  (in_state),
      .in_inv    (in_inv),
      .out_valid (out_valid_v[k]),
      .out_ready (out_ready),
      .out_state (out_state_v[k])
    );
  end

  // Primary device under test: BYTES_PER_CYCLE = 4
  logic         in_ready, out_valid;
  logic [127:0] out_state;
  assign in_ready  = in_ready_v[2];
  assign out_valid = out_valid_v[2];
  assign out_state = out_state_v[2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_tables();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] x, invx, s;
      x = 8'(i);
      invx = '0;
      for (int j = 1; j < 256; j++)
        if (gmul(x, 8'(j)) == 8'h01) invx = 8'(j);
      s = invx ^ rotl8(invx, 1) ^ rotl8(invx, 2) ^ rotl8(invx, 3) ^ rotl8(invx, 4) ^ 8'h63;
      fwd_tab[i] = s;
      inv_tab[s] = x;
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] st, input logic inv);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      b = st[127 - 8*i -: 8];
      r[127 - 8*i -: 8] = inv ? inv_tab[b] : fwd_tab[b];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Accept one block on the primary DUT and wait for its result.
  task automatic run_block(input logic [127:0] st, input logic inv,
                           output logic [127:0] got, output int lat);
    int w;
    w = 0;
    got = '0;
    lat = -1;
    while (!in_ready && w < 50) begin step(); w++; end
    if (!in_ready) begin
      check("accept_timeout", 128'(in_ready), 128'd1);
      return;
    end
    in_valid = 1'b1;
    in_state = st;
    in_inv   = inv;
    step();
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_inv   = ~inv;
    lat = 0;
    while (!out_valid && lat < 50) begin step(); lat++; end
    if (!out_valid) check("result_timeout", 128'(out_valid), 128'd1);
    got = out_state;
  endtask

  typedef struct packed {
    logic [127:0] st;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] FIPS_IN  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] FIPS_OUT = 128'h63cab7040953d051cd60e0e7ba70e18c;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [5];
    logic [127:0] got, exp;
    int           lat;
    int           lats [5];

    vecs[0] = '{st: FIPS_IN,  inv: 1'b0, exp: FIPS_OUT};
    vecs[1] = '{st: FIPS_OUT, inv: 1'b1, exp: FIPS_IN};
    vecs[2] = '{st: {16{8'h00}}, inv: 1'b0, exp: {16{8'h63}}};
    vecs[3] = '{st: {16{8'hff}}, inv: 1'b0, exp: {16{8'h16}}};
    vecs[4] = '{st: {16{8'hed}}, inv: 1'b1, exp: {16{8'h53}}};

    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_state = '0;
    build_tables();
    step(); step();
    check("reset_in_ready",  128'(in_ready),  128'd1);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_out_state", out_state, 128'd0);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      run_block(vecs[i].st, vecs[i].inv, got, lat);
      check($sformatf("vec%0d_state", i), got, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
      release_out();
    end

    // Backpressure: result held, input ignored while DONE
    run_block(FIPS_IN, 1'b0, got, lat);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin in_valid = 1'b1; in_state = {16{8'h00}}; in_inv = 1'b0; end
      step();
      in_valid = 1'b0;
      check($sformatf("bp_valid_c%0d", c),  128'(out_valid), 128'd1);
      check($sformatf("bp_ready_c%0d", c),  128'(in_ready),  128'd0);
      check($sformatf("bp_state_c%0d", c),  out_state, FIPS_OUT);
    end
    release_out();
    check("bp_after_valid", 128'(out_valid), 128'd0);
    check("bp_after_ready", 128'(in_ready),  128'd1);
    step(); step();
    check("bp_pulse_not_accepted", 128'(in_ready), 128'd1);

    // Reset in the middle of a block
    in_valid = 1'b1; in_state = FIPS_IN; in_inv = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_out_state", out_state, 128'd0);
    check("midrst_in_ready",  128'(in_ready),  128'd1);
    run_block(FIPS_IN, 1'b0, got, lat);
    check("midrst_fresh_state",   got, FIPS_OUT);
    check("midrst_fresh_latency", 128'(lat), 128'd4);
    release_out();

    // Randomized blocks against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [127:0] st;
      logic         inv;
      int           hold;
      st   = {$urandom, $urandom, $urandom, $urandom};
      inv  = 1'($urandom_range(0, 1));
      exp  = ref_sub(st, inv);
      run_block(st, inv, got, lat);
      check($sformatf("rand%0d_state", i), got, exp);
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) step();
      check($sformatf("rand%0d_held", i), out_state, exp);
      release_out();
    end

    // Parameter sweep: every lane count on the same vector
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_state = FIPS_IN; in_inv = 1'b0;
    step();
    in_valid = 1'b0;
    in_state = '1;
    for (int k = 0; k < 5; k++) lats[k] = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      for (int k = 0; k < 5; k++)
        if (lats[k] < 0 && out_valid_v[k]) lats[k] = c;
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("sweep_bpc%0d_latency", 1 << k), 128'(lats[k]), 128'(16 >> k));
      check($sformatf("sweep_bpc%0d_state", 1 << k), out_state_v[k], FIPS_OUT);
    end
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
